// File: rtl/note_sched.sv
// note_sched: byte-command note sequencer.
// Receives command bytes (one per rising edge of rx_stop) into a small FIFO and plays them
// one at a time: [7:3] is the pitch code (0 = rest), [2:0] is the duration in beats minus one.
// Each note is followed by a fixed silent gap.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset, overrides clr
//   rx_stop    - receiver byte-valid level; a rising edge pushes rx_data
//   rx_data    - command byte
//   play_en    - allows the next note to be loaded
//   clr        - synchronous flush of FIFO and abort of the current note
//   note       - pitch code of the current/last note
//   tone_on    - high while a non-rest note sounds
//   busy       - high in LOAD, PLAY and GAP
//   fifo_empty - FIFO holds no entries
//   fifo_full  - FIFO holds DEPTH entries
//   level      - FIFO occupancy, 0..DEPTH
//   ovf        - sticky flag, set when a push is dropped on a full FIFO
module note_sched #(
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 1250000,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_stop,
  input  logic [7:0]               rx_data,
  input  logic                     play_en,
  input  logic                     clr,
  output logic [4:0]               note,
  output logic                     tone_on,
  output logic                     busy,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BeatLast  = BW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GapLast   = GW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StPlay = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [4:0]    note_q, note_d;
  logic [2:0]    beats_q, beats_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          tone_q, busy_q, empty_q, full_q, ovf_q;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;

  logic          rx_prev_q;
  // Set once rx_stop has been seen low, so a level still high out of reset is not a push.
  logic          rx_armed_q;

  logic          push_req, push_ok, push_drop, pop, fifo_nonempty, full_now;
  logic [7:0]    head;

  assign push_req      = rx_stop & ~rx_prev_q & rx_armed_q;
  assign fifo_nonempty = (level_q != '0);
  assign full_now      = (level_q == LevelFull);
  assign pop           = (state_q == StLoad) && fifo_nonempty;
  // On a full FIFO a push is only accepted when the same edge frees a slot.
  assign push_ok       = push_req && (!full_now || pop);
  assign push_drop     = push_req && full_now && !pop;
  assign head          = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      StIdle: begin
        if (play_en && fifo_nonempty) state_d = StLoad;
      end
      StLoad: begin
        note_d     = head[7:3];
        beats_d    = head[2:0];
        beat_cnt_d = '0;
        state_d    = StPlay;
      end
      StPlay: begin
        if (beat_cnt_q == BeatLast) begin
          beat_cnt_d = '0;
          if (beats_q == 3'd0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            beats_d = beats_q - 3'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = (play_en && fifo_nonempty) ? StLoad : StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      note_q     <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      tone_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (clr) begin
      state_q    <= StIdle;
      note_q     <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      tone_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tone_q     <= (state_d == StPlay) && (note_d != 5'd0);
      busy_q     <= (state_d != StIdle);
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q    <= level_d;
      empty_q    <= (level_d == '0);
      full_q     <= (level_d == LevelFull);
      if (push_drop) ovf_q <= 1'b1;
    end
  end

  // Edge detector keeps tracking rx_stop through clr so a held level never re-pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev_q  <= 1'b0;
      rx_armed_q <= 1'b0;
    end else begin
      rx_prev_q <= rx_stop;
      if (!rx_stop) rx_armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr && push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

  assign note       = note_q;
  assign tone_on    = tone_q;
  assign busy       = busy_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign level      = level_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_note_sched.sv
// tb_note_sched: directed bench for note_sched (BEAT_CYCLES=4, GAP_CYCLES=2, DEPTH=4).
// Stimulus pushes the expected tone bursts (pitch, length in cycles) into a queue; a monitor
// measures every tone_on burst and compares it against the queue head.
module tb_note_sched;

  localparam int unsigned BEAT  = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, rx_stop, play_en, clr;
  logic [7:0] rx_data;
  logic [4:0] note;
  logic       tone_on, busy, fifo_empty, fifo_full, ovf;
  logic [$clog2(DEPTH):0] level;

  note_sched #(
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES (GAP),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_stop   (rx_stop),
    .rx_data   (rx_data),
    .play_en   (play_en),
    .clr       (clr),
    .note      (note),
    .tone_on   (tone_on),
    .busy      (busy),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .level     (level),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] pitch;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic exp_note(input logic [4:0] pitch, input int len);
    exp_t e;
    e.pitch = pitch;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One push: rising edge on the first tick, low again on the second.
  task automatic push(input logic [7:0] d);
    rx_data = d;
    rx_stop = 1'b1;
    tick();
    rx_stop = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    repeat (2) tick();
    while (busy && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, expected 0", busy, limit);
    end
  endtask

  // Monitor: measure each tone_on burst and score it against the expected queue.
  int         run = 0;
  logic [4:0] run_note;
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else if (tone_on) begin
      run++;
      run_note = note;
    end else if (run > 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_note: got pitch %0d len %0d, expected none", run_note, run);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("note_pitch", 32'(run_note), 32'(e.pitch));
        check("note_len", run, e.len);
      end
      run = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    rx_stop = 1'b1;
    rx_data = 8'h00;
    play_en = 1'b0;
    clr     = 1'b0;
    repeat (3) tick();
    check("rst_note", note, 0);
    check("rst_tone", tone_on, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", ovf, 0);

    // rx_stop still high after reset release must not push
    rst = 1'b0;
    repeat (3) tick();
    check("held_after_rst_level", level, 0);
    check("held_after_rst_empty", fifo_empty, 1);
    rx_stop = 1'b0;
    tick();

    // Single note 0x29: pitch 5, two beats
    play_en = 1'b1;
    exp_note(5'd5, 8);
    rx_data = 8'h29;
    rx_stop = 1'b1;
    tick();
    check("single_level_push", level, 1);
    rx_stop = 1'b0;
    tick();
    check("single_load_busy", busy, 1);
    check("single_load_tone", tone_on, 0);
    tick();
    check("single_play_tone", tone_on, 1);
    check("single_play_note", note, 5);
    check("single_play_level", level, 0);
    repeat (8) tick();
    check("single_gap_tone", tone_on, 0);
    check("single_gap_busy", busy, 1);
    repeat (2) tick();
    check("single_idle_busy", busy, 0);

    // Rest (one beat) followed by pitch 2 for two beats
    exp_note(5'd2, 8);
    push(8'h00);
    push(8'h11);
    check("rest_busy", busy, 1);
    check("rest_tone", tone_on, 0);
    check("rest_note", note, 0);
    check("rest_level", level, 1);
    repeat (2) tick();
    check("rest_end_busy", busy, 1);
    check("rest_end_tone", tone_on, 0);
    repeat (3) tick();
    check("rest_gap_load_tone", tone_on, 0);
    tick();
    check("after_rest_tone", tone_on, 1);
    check("after_rest_note", note, 2);
    wait_idle(100);

    // Overflow: five pushes into a four-entry FIFO, then play the first four in order
    play_en = 1'b0;
    push(8'h08);
    push(8'h13);
    push(8'h18);
    push(8'h21);
    push(8'h30);
    check("ovf_level", level, 4);
    check("ovf_full", fifo_full, 1);
    check("ovf_empty", fifo_empty, 0);
    check("ovf_flag", ovf, 1);
    exp_note(5'd1, 4);
    exp_note(5'd2, 16);
    exp_note(5'd3, 4);
    exp_note(5'd4, 8);
    play_en = 1'b1;
    wait_idle(300);
    check("ovf_drain_level", level, 0);
    check("ovf_drain_empty", fifo_empty, 1);
    check("ovf_sticky", ovf, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", ovf, 0);

    // Full FIFO with a push on the LOAD edge
    play_en = 1'b0;
    push(8'h08);
    push(8'h10);
    push(8'h18);
    push(8'h20);
    check("full_level", level, 4);
    exp_note(5'd1, 4);
    exp_note(5'd2, 4);
    exp_note(5'd3, 4);
    exp_note(5'd4, 4);
    exp_note(5'd5, 4);
    play_en = 1'b1;
    tick();
    check("full_load_busy", busy, 1);
    rx_data = 8'h28;
    rx_stop = 1'b1;
    tick();
    rx_stop = 1'b0;
    check("full_pushpop_level", level, 4);
    check("full_pushpop_ovf", ovf, 0);
    check("full_pushpop_full", fifo_full, 1);
    wait_idle(300);
    check("full_drain_level", level, 0);
    check("full_drain_ovf", ovf, 0);

    // clr mid-note with two entries queued; the cut note sounded for six cycles
    exp_note(5'd1, 6);
    push(8'h0B);
    push(8'h10);
    push(8'h18);
    check("clr_pre_level", level, 2);
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_tone", tone_on, 0);
    check("clr_busy", busy, 0);
    check("clr_level", level, 0);
    check("clr_empty", fifo_empty, 1);
    repeat (40) tick();
    check("clr_stays_idle", busy, 0);
    check("clr_stays_empty", level, 0);

    // rx_stop held high for 10 cycles is one push; dropping play_en mid-note
    exp_note(5'd2, 16);
    rx_data = 8'h13;
    rx_stop = 1'b1;
    repeat (10) tick();
    check("hold_level", level, 0);
    check("hold_busy", busy, 1);
    check("hold_tone", tone_on, 1);
    rx_stop = 1'b0;
    tick();
    push(8'h18);
    check("hold_queued_level", level, 1);
    play_en = 1'b0;
    check("playen_tone_continues", tone_on, 1);
    wait_idle(100);
    check("playen_idle_level", level, 1);
    repeat (10) tick();
    check("playen_stays_idle", busy, 0);
    check("playen_level_kept", level, 1);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
